// File: rtl/timer_bank.sv
// timer_bank: memory-mapped bank of NUM_TIMERS reload timers plus LED/digit
// output registers, a free-running 32-bit systick and an interrupt-status view.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   reset      asynchronous, active-high reset
//   rd         read strobe; rdata is zero when low
//   wr         write strobe, sampled on the rising clk edge
//   addr       byte address
//   wdata      write data
//   rdata      combinational read data
//   irq_block  high while the CPU cannot accept an interrupt
//   led        LED register
//   digi       digit register
//   irqout     interrupt request: any (PEND & IE), masked by irq_block
//
// Map: timer i at BASE_ADDR + 0x10*i  (+0 TH, +4 TL, +8 TCON)
//      shared at BASE_ADDR + 0x10*NUM_TIMERS (+0 LED, +4 DIGI, +8 SYSTICK, +C IRQSTAT)
//      TCON: bit0 EN, bit1 IE, bit2 PEND (write-1-to-clear), bit3 ONESHOT
module timer_bank #(
    parameter int          NUM_TIMERS = 2,
    parameter int          CNT_W      = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter int          LED_W      = 8,
    parameter int          DIGI_W     = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    input  logic              irq_block,
    output logic [LED_W-1:0]  led,
    output logic [DIGI_W-1:0] digi,
    output logic              irqout
);

    localparam logic [31:0]      SHARED_OFF = 32'(NUM_TIMERS * 16);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [CNT_W-1:0]      th [NUM_TIMERS];
    logic [CNT_W-1:0]      tl [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] en;
    logic [NUM_TIMERS-1:0] ie;
    logic [NUM_TIMERS-1:0] pend;
    logic [NUM_TIMERS-1:0] oneshot;
    logic [31:0]           systick;

    // Address decode. The offset wraps for addresses below the base, which
    // lands it far outside both windows, so no separate lower-bound check.
    logic [31:0] offset;
    logic        word_ok;
    logic        timer_hit;
    logic        shared_hit;
    logic [2:0]  tsel;
    logic [1:0]  rsel;

    assign offset     = addr - BASE_ADDR;
    assign word_ok    = (offset[1:0] == 2'b00);
    assign timer_hit  = word_ok && (offset < SHARED_OFF);
    assign shared_hit = word_ok && (offset[31:4] == SHARED_OFF[31:4]);
    assign tsel       = offset[6:4];
    assign rsel       = offset[3:2];

    logic [NUM_TIMERS-1:0] wr_th;
    logic [NUM_TIMERS-1:0] wr_tl;
    logic [NUM_TIMERS-1:0] wr_tcon;
    logic [NUM_TIMERS-1:0] ovf;
    logic                  wr_led;
    logic                  wr_digi;

    always_comb begin
        wr_th   = '0;
        wr_tl   = '0;
        wr_tcon = '0;
        ovf     = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            ovf[i] = en[i] && (tl[i] == '1);
            if (wr && timer_hit && (tsel == 3'(i))) begin
                case (rsel)
                    2'd0:    wr_th[i]   = 1'b1;
                    2'd1:    wr_tl[i]   = 1'b1;
                    2'd2:    wr_tcon[i] = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign wr_led  = wr && shared_hit && (rsel == 2'd0);
    assign wr_digi = wr && shared_hit && (rsel == 2'd1);

    // Timer channels. A CPU write to TL beats the reload, while an overflow
    // setting PEND beats a simultaneous write-1-to-clear. Counting uses the
    // EN value held before this edge, so a TCON write takes effect next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                th[i] <= '0;
                tl[i] <= '0;
            end
            en      <= '0;
            ie      <= '0;
            pend    <= '0;
            oneshot <= '0;
        end else begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (wr_th[i])
                    th[i] <= wdata[CNT_W-1:0];

                if (wr_tl[i])
                    tl[i] <= wdata[CNT_W-1:0];
                else if (ovf[i])
                    tl[i] <= th[i];
                else if (en[i])
                    tl[i] <= tl[i] + CNT_ONE;

                if (wr_tcon[i]) begin
                    en[i]      <= wdata[0];
                    ie[i]      <= wdata[1];
                    oneshot[i] <= wdata[3];
                end else if (ovf[i] && oneshot[i]) begin
                    en[i] <= 1'b0;
                end

                if (ovf[i] && ie[i])
                    pend[i] <= 1'b1;
                else if (wr_tcon[i] && wdata[2])
                    pend[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led     <= '0;
            digi    <= '0;
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;
            if (wr_led)
                led <= wdata[LED_W-1:0];
            if (wr_digi)
                digi <= wdata[DIGI_W-1:0];
        end
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (timer_hit) begin
                for (int i = 0; i < NUM_TIMERS; i++) begin
                    if (tsel == 3'(i)) begin
                        case (rsel)
                            2'd0:    rdata = 32'(th[i]);
                            2'd1:    rdata = 32'(tl[i]);
                            2'd2:    rdata = {28'd0, oneshot[i], pend[i], ie[i], en[i]};
                            default: rdata = '0;
                        endcase
                    end
                end
            end else if (shared_hit) begin
                case (rsel)
                    2'd0:    rdata = 32'(led);
                    2'd1:    rdata = 32'(digi);
                    2'd2:    rdata = systick;
                    default: rdata = 32'(pend);
                endcase
            end
        end
    end

    assign irqout = (|(pend & ie)) & ~irq_block;

endmodule

// File: tb/tb_timer_bank.sv
module tb_timer_bank;

    localparam int          NT   = 2;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] S    = BASE + 32'h20;

    localparam int K_NONE = 0, K_TH = 1, K_TL = 2, K_TCON = 3;
    localparam int K_LED  = 4, K_DIGI = 5, K_TICK = 6, K_STAT = 7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq_block = 1'b0;
    logic [7:0]  led;
    logic [11:0] digi;
    logic        irqout;

    int n_cmp = 0;
    int n_err = 0;

    timer_bank #(
        .NUM_TIMERS(NT),
        .CNT_W(32),
        .BASE_ADDR(BASE),
        .LED_W(8),
        .DIGI_W(12)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rd(rd),
        .wr(wr),
        .addr(addr),
        .wdata(wdata),
        .rdata(rdata),
        .irq_block(irq_block),
        .led(led),
        .digi(digi),
        .irqout(irqout)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m_th   [NT];
    logic [31:0] m_tl   [NT];
    logic        m_en   [NT];
    logic        m_ie   [NT];
    logic        m_pend [NT];
    logic        m_os   [NT];
    logic [7:0]  m_led;
    logic [11:0] m_digi;
    logic [31:0] m_tick;

    function automatic longint off_of(input logic [31:0] a);
        longint ua;
        longint ub;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, BASE});
        return ua - ub;
    endfunction

    function automatic int kind_of(input logic [31:0] a);
        longint off;
        off = off_of(a);
        if (off < 0 || (off % 4) != 0) return K_NONE;
        if (off < 16 * NT) begin
            case (int'((off % 16) / 4))
                0:       return K_TH;
                1:       return K_TL;
                2:       return K_TCON;
                default: return K_NONE;
            endcase
        end
        if (off < 16 * NT + 16) return K_LED + int'((off - 16 * NT) / 4);
        return K_NONE;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'(off_of(a) / 16);
    endfunction

    function automatic bit hit(input int k, input int t);
        return wr && (kind_of(addr) == k) && (idx_of(addr) == t);
    endfunction

    function automatic bit wraps(input int t);
        return m_en[t] && (m_tl[t] == 32'hFFFF_FFFF);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < NT; t++) begin
                m_th[t]   <= '0;
                m_tl[t]   <= '0;
                m_en[t]   <= 1'b0;
                m_ie[t]   <= 1'b0;
                m_pend[t] <= 1'b0;
                m_os[t]   <= 1'b0;
            end
            m_led  <= '0;
            m_digi <= '0;
            m_tick <= '0;
        end else begin
            m_tick <= m_tick + 32'd1;
            if (wr && kind_of(addr) == K_LED)  m_led  <= wdata[7:0];
            if (wr && kind_of(addr) == K_DIGI) m_digi <= wdata[11:0];
            for (int t = 0; t < NT; t++) begin
                if (hit(K_TH, t)) m_th[t] <= wdata;
                if (hit(K_TL, t))      m_tl[t] <= wdata;
                else if (wraps(t))     m_tl[t] <= m_th[t];
                else if (m_en[t])      m_tl[t] <= m_tl[t] + 32'd1;
                if (hit(K_TCON, t)) begin
                    m_en[t] <= wdata[0];
                    m_ie[t] <= wdata[1];
                    m_os[t] <= wdata[3];
                end else if (wraps(t) && m_os[t]) begin
                    m_en[t] <= 1'b0;
                end
                if (wraps(t) && m_ie[t])             m_pend[t] <= 1'b1;
                else if (hit(K_TCON, t) && wdata[2]) m_pend[t] <= 1'b0;
            end
        end
    end

    function automatic logic [31:0] exp_rdata();
        int          t;
        logic [31:0] st;
        if (!rd) return 32'd0;
        t  = idx_of(addr);
        st = '0;
        for (int i = 0; i < NT; i++) st[i] = m_pend[i];
        case (kind_of(addr))
            K_TH:    return m_th[t];
            K_TL:    return m_tl[t];
            K_TCON:  return {28'd0, m_os[t], m_pend[t], m_ie[t], m_en[t]};
            K_LED:   return {24'd0, m_led};
            K_DIGI:  return {20'd0, m_digi};
            K_TICK:  return m_tick;
            K_STAT:  return st;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic exp_irq();
        logic any;
        any = 1'b0;
        for (int i = 0; i < NT; i++) any = any | (m_pend[i] & m_ie[i]);
        return any & ~irq_block;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_rdata", rdata, exp_rdata());
        chk("model_led", {24'd0, led}, {24'd0, m_led});
        chk("model_digi", {20'd0, digi}, {20'd0, m_digi});
        chk("model_irqout", {31'd0, irqout}, {31'd0, exp_irq()});
    end

    // ---------------- directed stimulus ----------------
    function automatic logic [31:0] ta(input int t, input int r);
        return BASE + 32'(16 * t + 4 * r);
    endfunction

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        wr    = 1'b1;
        rd    = 1'b0;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        rd   = 1'b1;
        addr = a;
        #1;
        chk(nm, rdata, e);
    endtask

    logic [31:0] ar_exp [5];

    initial begin
        ar_exp[0] = 32'hFFFF_FFFC;
        ar_exp[1] = 32'hFFFF_FFFD;
        ar_exp[2] = 32'hFFFF_FFFE;
        ar_exp[3] = 32'hFFFF_FFFF;
        ar_exp[4] = 32'hFFFF_FFFC;

        @(posedge clk);
        #1;
        for (int t = 0; t < NT; t++)
            for (int r = 0; r < 3; r++)
                rd_chk("reset_timer_reg", ta(t, r), 32'd0);
        for (int r = 0; r < 4; r++)
            rd_chk("reset_shared_reg", S + 32'(4 * r), 32'd0);
        rd   = 1'b0;
        addr = S + 32'h8;
        #1;
        chk("rd_low_zero", rdata, 32'd0);
        rd_chk("unmapped_zero", S + 32'h10, 32'd0);

        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(7);
        rd_chk("systick_7", S + 32'h8, 32'd7);

        // auto-reload on timer 0
        wr_reg(ta(0, 0), 32'hFFFF_FFFC);
        wr_reg(ta(0, 1), 32'hFFFF_FFFC);
        wr_reg(ta(0, 2), 32'h3);
        for (int i = 0; i < 5; i++) begin
            rd_chk("ar_tl_step", ta(0, 1), ar_exp[i]);
            if (i < 4) idle(1);
        end
        chk("ar_irqout", {31'd0, irqout}, 32'd1);
        rd_chk("ar_irqstat", S + 32'hC, 32'h1);

        // masking
        irq_block = 1'b1;
        #1;
        chk("mask_block", {31'd0, irqout}, 32'd0);
        irq_block = 1'b0;
        #1;
        chk("mask_release", {31'd0, irqout}, 32'd1);
        wr_reg(ta(0, 2), 32'h1);
        chk("mask_ie_off", {31'd0, irqout}, 32'd0);
        rd_chk("mask_pend_kept", S + 32'hC, 32'h1);

        // collisions on timer 0
        wr_reg(ta(0, 2), 32'h4);
        rd_chk("col_cleared", S + 32'hC, 32'h0);
        wr_reg(ta(0, 1), 32'hFFFF_FFFE);
        wr_reg(ta(0, 2), 32'h3);
        idle(1);
        wr_reg(ta(0, 2), 32'h7);
        rd_chk("col_w1c_stat", S + 32'hC, 32'h1);
        rd_chk("col_w1c_tcon", ta(0, 2), 32'h7);
        idle(3);
        wr_reg(ta(0, 1), 32'h5);
        rd_chk("col_tl_write", ta(0, 1), 32'h5);
        wr_reg(ta(0, 2), 32'h0);
        wr_reg(ta(0, 2), 32'h4);
        rd_chk("t0_cleared", S + 32'hC, 32'h0);

        // one-shot on timer 1
        wr_reg(ta(1, 0), 32'hFFFF_FFFC);
        wr_reg(ta(1, 1), 32'hFFFF_FFFC);
        wr_reg(ta(1, 2), 32'hB);
        idle(4);
        rd_chk("os_tcon", ta(1, 2), 32'hE);
        rd_chk("os_tl", ta(1, 1), 32'hFFFF_FFFC);
        chk("os_irqout", {31'd0, irqout}, 32'd1);
        idle(3);
        rd_chk("os_frozen", ta(1, 1), 32'hFFFF_FFFC);
        wr_reg(ta(1, 2), 32'h4);
        chk("os_clr_irqout", {31'd0, irqout}, 32'd0);
        rd_chk("os_clr_stat", S + 32'hC, 32'h0);

        // shared registers and read-only writes
        wr_reg(S, 32'h1A5);
        chk("led_trunc", {24'd0, led}, 32'hA5);
        wr_reg(S + 32'h4, 32'hFFFF);
        chk("digi_trunc", {20'd0, digi}, 32'hFFF);
        rd_chk("led_read", S, 32'hA5);
        wr_reg(S + 32'h8, 32'h0);
        wr_reg(S + 32'hC, 32'hFF);
        wr_reg(S + 32'h10, 32'h1234);

        // asynchronous reset while timer 0 is pending
        wr_reg(ta(0, 1), 32'hFFFF_FFFE);
        wr_reg(ta(0, 2), 32'h3);
        idle(2);
        rd_chk("pre_rst_stat", S + 32'hC, 32'h1);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_async_stat", rdata, 32'd0);
        chk("rst_async_irq", {31'd0, irqout}, 32'd0);
        chk("rst_async_led", {24'd0, led}, 32'd0);
        chk("rst_async_digi", {20'd0, digi}, 32'd0);
        idle(2);
        reset = 1'b0;
        rd_chk("post_rst_tl", ta(0, 1), 32'd0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
